// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared constants, types and round-robin helper for the bus arbiter
package bus_arbiter_pkg;

    // Active-low bus signalling levels
    localparam logic ENABLE_       = 1'b0;
    localparam logic DISABLE_      = 1'b1;

    // Active-low reset levels
    localparam logic RESET_ENABLE  = 1'b0;
    localparam logic RESET_DISABLE = 1'b1;

    // Plain logic levels
    localparam logic HIGH          = 1'b1;
    localparam logic LOW           = 1'b0;

    // Owner encoding
    localparam int OWNER_W     = 2;
    localparam int NUM_MASTERS = 4;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // Next owner given the current owner and the active-low request vector.
    // The owner keeps the bus while its request stays asserted; otherwise the
    // search walks the masters after the owner, wrapping modulo four, and the
    // first asserted request wins. With nobody else asking the bus stays parked.
    function automatic owner_t rr_next(input owner_t cur, input logic [NUM_MASTERS-1:0] req_n);
        owner_t nxt;
        owner_t cand;
        logic   found;
        nxt   = cur;
        found = LOW;
        if (req_n[cur] != ENABLE_) begin
            for (int k = 1; k < NUM_MASTERS; k++) begin
                cand = cur + owner_t'(k);
                if ((found == LOW) && (req_n[cand] == ENABLE_)) begin
                    nxt   = cand;
                    found = HIGH;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with active-low request/grant
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic m0_req_,
    input  logic m1_req_,
    input  logic m2_req_,
    input  logic m3_req_,
    output logic m0_grnt_,
    output logic m1_grnt_,
    output logic m2_grnt_,
    output logic m3_grnt_
);

    owner_t                  owner;
    logic [NUM_MASTERS-1:0]  req_n;

    assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

    // Owner register: reset parks the bus on master 0, otherwise round-robin handover.
    // Grants depend only on this register, so a request never reaches a grant
    // before the next rising edge.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            owner <= BUS_OWNER_MASTER_0;
        end else begin
            owner <= rr_next(owner, req_n);
        end
    end

    // One-hot-low grant decode of the owner register.
    always_comb begin
        m0_grnt_ = DISABLE_;
        m1_grnt_ = DISABLE_;
        m2_grnt_ = DISABLE_;
        m3_grnt_ = DISABLE_;
        case (owner)
            BUS_OWNER_MASTER_0: m0_grnt_ = ENABLE_;
            BUS_OWNER_MASTER_1: m1_grnt_ = ENABLE_;
            BUS_OWNER_MASTER_2: m2_grnt_ = ENABLE_;
            BUS_OWNER_MASTER_3: m3_grnt_ = ENABLE_;
            default:            m0_grnt_ = ENABLE_;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed table-driven bench for the round-robin bus arbiter
module tb_bus_arbiter;

    logic clk;
    logic reset;
    logic m0_req_, m1_req_, m2_req_, m3_req_;
    logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;

    int n_checks;
    int n_fails;

    bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vectors are {m3,m2,m1,m0}, active-low.
    localparam logic [3:0] G0 = 4'b1110;
    localparam logic [3:0] G1 = 4'b1101;
    localparam logic [3:0] G2 = 4'b1011;
    localparam logic [3:0] G3 = 4'b0111;
    localparam logic [3:0] RN = 4'b1111;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.grnt  = g;
        return v;
    endfunction

    function automatic logic [3:0] grnt_vec();
        return {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    endfunction

    task automatic drive(input logic r, input logic [3:0] q);
        reset   = r;
        m0_req_ = q[0];
        m1_req_ = q[1];
        m2_req_ = q[2];
        m3_req_ = q[3];
    endtask

    task automatic check(input string tag, input int idx, input logic [3:0] want);
        logic [3:0] got;
        got = grnt_vec();
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s[%0d] grnt={m3,m2,m1,m0} got %b expected %b", tag, idx, got, want);
        end
    endtask

    logic [3:0] prev;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        drive(1'b0, RN);

        // Reset held three cycles, then idle: parked on m0
        vecs.push_back(mk(1'b0, RN, G0));
        vecs.push_back(mk(1'b0, RN, G0));
        vecs.push_back(mk(1'b0, RN, G0));
        vecs.push_back(mk(1'b1, RN, G0));
        vecs.push_back(mk(1'b1, RN, G0));
        // m0 holds while others pile on
        vecs.push_back(mk(1'b1, 4'b1110, G0));
        vecs.push_back(mk(1'b1, 4'b1100, G0));
        vecs.push_back(mk(1'b1, 4'b1000, G0));
        vecs.push_back(mk(1'b1, 4'b0000, G0));
        // Successive releases hand over 0->1->2->3
        vecs.push_back(mk(1'b1, 4'b0001, G1));
        vecs.push_back(mk(1'b1, 4'b0011, G2));
        vecs.push_back(mk(1'b1, 4'b0111, G3));
        // Idle park on m3
        vecs.push_back(mk(1'b1, RN, G3));
        vecs.push_back(mk(1'b1, RN, G3));
        vecs.push_back(mk(1'b1, RN, G3));
        // m3 holding, reset pulled one edge
        vecs.push_back(mk(1'b1, 4'b0111, G3));
        vecs.push_back(mk(1'b0, 4'b0111, G0));
        // First edge out of reset arbitrates from owner 0: order 1,2,3 -> m3
        vecs.push_back(mk(1'b1, 4'b0111, G3));
        // From owner 3 only m2 asks -> m2, then m2 holds
        vecs.push_back(mk(1'b1, 4'b1011, G2));
        vecs.push_back(mk(1'b1, 4'b1011, G2));
        // Owner 2 releases, m0 and m1 ask: order 3,0,1 -> m0
        vecs.push_back(mk(1'b1, 4'b1100, G0));
        // Owner 0 releases, m2 and m3 ask: order 1,2,3 -> m2
        vecs.push_back(mk(1'b1, 4'b0011, G2));
        // Owner 2 releases, m3 asks -> m3
        vecs.push_back(mk(1'b1, 4'b0111, G3));
        // Owner 3 releases, m1 and m2 ask: order 0,1,2 -> m1
        vecs.push_back(mk(1'b1, 4'b1001, G1));
        // Owner 1 releases, m0 and m3 ask: order 2,3,0 -> m3
        vecs.push_back(mk(1'b1, 4'b0110, G3));

        prev = RN;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].req);
            #1;
            // Grant must not move before the edge that samples the new inputs
            if (i > 0) check("pre_edge", i, prev);
            @(posedge clk);
            #1;
            check("vec", i, vecs[i].grnt);
            prev = vecs[i].grnt;
        end

        // Long hold: owner m3 keeps req_ low while everyone else requests
        @(negedge clk);
        drive(1'b1, 4'b0000);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check("hold_m3", c, G3);
        end

        // Release m3 with all others asking: order 0,1,2 -> m0, then chain onward
        @(negedge clk);
        drive(1'b1, 4'b1000);
        @(posedge clk);
        #1;
        check("wrap_m0", 0, G0);
        @(negedge clk);
        drive(1'b1, 4'b1001);
        @(posedge clk);
        #1;
        check("wrap_m1", 0, G1);

        // Long idle park on m1
        @(negedge clk);
        drive(1'b1, RN);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("park_m1", c, G1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
